whack_key_scheduler: RTL and testbench

- Sits between the PS/2 key-press driver and the whac-a-mole game FSM.
- Maps scan codes for the nine hole keys (Q W E / A S D / Z X C) to hole indices 0-8, and tracks which of those keys are held.
- Applies a per-hole re-hit lockout and queues accepted hits in a small FIFO.
- The game logic drains the FIFO through a valid/ready handshake.

---
 rtl/whack_key_scheduler.sv | 171 +++++++++++++++++
 tb/tb_whack_key_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/whack_key_scheduler.sv
// whack_key_scheduler
//   Sits between the PS/2 key-press driver and the whac-a-mole game FSM.
//   It decodes the nine hole keys (Q W E / A S D / Z X C) to hole indices
//   0-8 and tracks which of those keys are held down. Each hole has a re-hit
//   lockout. Accepted hits are queued in a first-word-fall-through FIFO, and
//   the game drains that FIFO with a valid/ready handshake.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   LOCK_CYCLES  cycles a hole stays locked after an accepted hit (0 = off)
//   LOCK_W       lock counter width, LOCK_CYCLES < 2**LOCK_W
//
// Ports
//   CLOCK_50      system clock, rising edge
//   resetn        asynchronous active-low reset
//   key_valid     one-cycle key event strobe
//   key_make      1 = press, 0 = release (qualified by key_valid)
//   key_code      set-2 scan code (qualified by key_valid)
//   game_active   1 = accept hits, 0 = flush FIFO / clear locks
//   hit_ready     consumer takes the head entry
//   clr_overflow  clears the sticky overflow flag
//   hit_valid     FIFO non-empty
//   hit_hole      hole index at the FIFO head (0 when empty)
//   held          bit h = key for hole h is held
//   fifo_count    queued entries, 0..DEPTH
//   overflow      sticky: a hit was dropped on a full FIFO
module whack_key_scheduler #(
    parameter int DEPTH       = 4,
    parameter int LOCK_CYCLES = 2500000,
    parameter int LOCK_W      = 22
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic                     key_valid,
    input  logic                     key_make,
    input  logic [7:0]               key_code,
    input  logic                     game_active,
    input  logic                     hit_ready,
    input  logic                     clr_overflow,
    output logic                     hit_valid,
    output logic [3:0]               hit_hole,
    output logic [8:0]               held,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCK_CYCLES);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [3:0]        dec_hole;
    logic [8:0]        dec_onehot;
    logic              dec_hit;
    logic [8:0]        lock_idle;
    logic              ev_make;
    logic              ev_break;
    logic              push_req;
    logic              push_ok;
    logic              drop;
    logic              pop;
    logic              full;

    logic [LOCK_W-1:0] lock_q [9];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [3:0]        mem [DEPTH];

    // Scan-code decode; anything outside the nine hole keys is ignored.
    always_comb begin
        dec_hit  = 1'b1;
        dec_hole = 4'd0;
        case (key_code)
            8'h15:   dec_hole = 4'd0;
            8'h1D:   dec_hole = 4'd1;
            8'h24:   dec_hole = 4'd2;
            8'h1C:   dec_hole = 4'd3;
            8'h1B:   dec_hole = 4'd4;
            8'h23:   dec_hole = 4'd5;
            8'h1A:   dec_hole = 4'd6;
            8'h22:   dec_hole = 4'd7;
            8'h21:   dec_hole = 4'd8;
            default: dec_hit  = 1'b0;
        endcase
        dec_onehot = dec_hit ? (9'd1 << dec_hole) : 9'd0;
    end

    always_comb begin
        for (int h = 0; h < 9; h++) begin
            lock_idle[h] = (lock_q[h] == '0);
        end
    end

    assign ev_make  = key_valid & key_make & dec_hit;
    assign ev_break = key_valid & ~key_make & dec_hit;

    // A push needs a fresh press (not typematic repeat) on an unlocked hole.
    assign push_req = ev_make & game_active & (|(dec_onehot & ~held & lock_idle));

    assign hit_valid = (fifo_count != '0);
    assign full      = (fifo_count == FULL_COUNT);
    assign pop       = hit_valid & hit_ready;

    // On a full FIFO a simultaneous pop frees the slot the push lands in.
    assign push_ok = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;

    assign hit_hole = hit_valid ? mem[rd_ptr] : 4'd0;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            held       <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            for (int h = 0; h < 9; h++) begin
                lock_q[h] <= '0;
            end
        end else begin
            if (ev_make) begin
                held <= held | dec_onehot;
            end else if (ev_break) begin
                held <= held & ~dec_onehot;
            end

            // Drop beats clear when both happen in one cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end

            if (!game_active) begin
                fifo_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                for (int h = 0; h < 9; h++) begin
                    lock_q[h] <= '0;
                end
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push_ok, pop})
                    2'b10:   fifo_count <= fifo_count + 1'b1;
                    2'b01:   fifo_count <= fifo_count - 1'b1;
                    default: fifo_count <= fifo_count;
                endcase
                // Lock is armed even when the hit is dropped on overflow.
                for (int h = 0; h < 9; h++) begin
                    if (push_req && dec_onehot[h]) begin
                        lock_q[h] <= LOCK_LOAD;
                    end else if (!lock_idle[h]) begin
                        lock_q[h] <= lock_q[h] - 1'b1;
                    end
                end
            end
        end
    end

    // FIFO storage carries no reset; hit_hole is masked while empty.
    always_ff @(posedge CLOCK_50) begin
        if (push_ok) begin
            mem[wr_ptr] <= dec_hole;
        end
    end

endmodule

// File: tb/tb_whack_key_scheduler.sv
module tb_whack_key_scheduler;

    localparam int DEPTH = 4;
    localparam int L     = 10;
    localparam int LW    = 8;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_make = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       game_active = 1'b0;
    logic       hit_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       hit_valid;
    logic [3:0] hit_hole;
    logic [8:0] held;
    logic [2:0] fifo_count;
    logic       overflow;

    always #5 CLOCK_50 = ~CLOCK_50;

    whack_key_scheduler #(.DEPTH(DEPTH), .LOCK_CYCLES(L), .LOCK_W(LW)) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .key_valid    (key_valid),
        .key_make     (key_make),
        .key_code     (key_code),
        .game_active  (game_active),
        .hit_ready    (hit_ready),
        .clr_overflow (clr_overflow),
        .hit_valid    (hit_valid),
        .hit_hole     (hit_hole),
        .held         (held),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h1C, 8'h1B, 8'h23, 8'h1A, 8'h22, 8'h21};

    function automatic int hole_of(input logic [7:0] c);
        for (int i = 0; i < 9; i++) begin
            if (codes[i] == c) return i;
        end
        return -1;
    endfunction

    int       q[$];
    logic [8:0] held_m = '0;
    int       last_m [9];
    bit       ovf_m = 1'b0;
    int       cyc = 0;
    int       m_h;
    bit       m_pop, m_full, m_acc, m_drop;

    initial begin
        for (int i = 0; i < 9; i++) last_m[i] = -1000;
    end

    // Model state advances on each rising edge from the inputs of that cycle.
    always @(posedge CLOCK_50) begin
        cyc++;
        if (!resetn) begin
            q.delete();
            held_m = '0;
            ovf_m  = 1'b0;
            for (int i = 0; i < 9; i++) last_m[i] = -1000;
        end else begin
            m_h    = key_valid ? hole_of(key_code) : -1;
            m_pop  = (q.size() != 0) && hit_ready;
            m_full = (q.size() == DEPTH);
            m_acc  = 1'b0;
            if (m_h >= 0 && key_make)
                m_acc = game_active && !held_m[m_h] && (cyc - last_m[m_h] > L);
            if (m_h >= 0) held_m[m_h] = key_make;
            m_drop = m_acc && m_full && !m_pop;
            if (m_drop) ovf_m = 1'b1;
            else if (clr_overflow) ovf_m = 1'b0;
            if (!game_active) begin
                q.delete();
                for (int i = 0; i < 9; i++) last_m[i] = -1000;
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_acc) begin
                    last_m[m_h] = cyc;
                    if (!m_drop) q.push_back(m_h);
                end
            end
        end
    end

    // Per-cycle comparison, sampled just after the rising edge.
    always @(posedge CLOCK_50) begin
        #1;
        check("cyc_hit_valid",  hit_valid,  q.size() != 0);
        check("cyc_hit_hole",   hit_hole,   (q.size() != 0) ? q[0] : 0);
        check("cyc_held",       held,       held_m);
        check("cyc_fifo_count", fifo_count, q.size());
        check("cyc_overflow",   overflow,   ovf_m);
    end

    // ---------------- stimulus helpers ----------------
    task automatic ev(input bit mk, input logic [7:0] c);
        @(negedge CLOCK_50);
        key_valid = 1'b1;
        key_make  = mk;
        key_code  = c;
        @(negedge CLOCK_50);
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic pop1();
        @(negedge CLOCK_50);
        hit_ready = 1'b1;
        @(negedge CLOCK_50);
        hit_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        idle(2);
        check("rst_hit_valid",  hit_valid,  0);
        check("rst_hit_hole",   hit_hole,   0);
        check("rst_held",       held,       0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow",   overflow,   0);
        resetn = 1'b1;
        game_active = 1'b1;
        idle(1);

        // Single hit, one-cycle latency, then pop
        ev(1, 8'h1B);
        check("s1_valid", hit_valid, 1);
        check("s1_hole",  hit_hole,  4);
        check("s1_held",  held,      9'b000010000);
        pop1();
        check("s1_valid_after_pop", hit_valid,  0);
        check("s1_count_after_pop", fifo_count, 0);
        ev(0, 8'h1B);

        // Typematic repeat
        ev(1, 8'h15);
        ev(1, 8'h15);
        ev(0, 8'h15);
        check("s2_count", fifo_count, 1);
        check("s2_hole",  hit_hole,   0);
        check("s2_held0", held[0],    0);
        pop1();

        // Lockout: short gaps blocked, long gaps accepted
        ev(1, 8'h24); idle(3);
        ev(0, 8'h24); idle(3);
        ev(1, 8'h24);
        check("s3_short_count", fifo_count, 1);
        ev(0, 8'h24);
        pop1();
        idle(12);
        ev(1, 8'h24); idle(12);
        ev(0, 8'h24); idle(12);
        ev(1, 8'h24);
        check("s3_long_count", fifo_count, 2);
        check("s3_head_a", hit_hole, 2);
        pop1();
        check("s3_head_b", hit_hole, 2);
        pop1();
        ev(0, 8'h24);
        idle(12);

        // Overflow with five distinct holes
        ev(1, 8'h15); ev(1, 8'h1D); ev(1, 8'h24); ev(1, 8'h1C); ev(1, 8'h1B);
        check("s4_count",    fifo_count, 4);
        check("s4_overflow", overflow,   1);
        for (int i = 0; i < 4; i++) begin
            check("s4_pop_order", hit_hole, i);
            pop1();
        end
        check("s4_empty", hit_valid, 0);
        @(negedge CLOCK_50); clr_overflow = 1'b1;
        @(negedge CLOCK_50); clr_overflow = 1'b0;
        check("s4_clr", overflow, 0);
        for (int i = 0; i < 5; i++) ev(0, codes[i]);
        idle(12);

        // Full FIFO: push and pop together
        ev(1, 8'h15); ev(1, 8'h1D); ev(1, 8'h24); ev(1, 8'h1C);
        check("s5_full", fifo_count, 4);
        @(negedge CLOCK_50);
        key_valid = 1'b1; key_make = 1'b1; key_code = 8'h1B; hit_ready = 1'b1;
        @(negedge CLOCK_50);
        key_valid = 1'b0; hit_ready = 1'b0;
        check("s5_count",    fifo_count, 4);
        check("s5_overflow", overflow,   0);
        for (int i = 1; i <= 4; i++) begin
            check("s5_order", hit_hole, i);
            pop1();
        end
        for (int i = 0; i < 5; i++) ev(0, codes[i]);
        idle(12);

        // Flush on game_active=0, held still tracked, unmapped code ignored
        ev(1, 8'h1A); ev(1, 8'h22);
        check("s6_count", fifo_count, 2);
        @(negedge CLOCK_50); game_active = 1'b0;
        @(negedge CLOCK_50);
        check("s6_flush_valid", hit_valid,  0);
        check("s6_flush_count", fifo_count, 0);
        ev(1, 8'h21);
        check("s6_no_push", hit_valid, 0);
        check("s6_held8",   held,      9'b111000000);
        ev(1, 8'h76);
        check("s6_unmapped_held",  held,       9'b111000000);
        check("s6_unmapped_count", fifo_count, 0);
        @(negedge CLOCK_50); game_active = 1'b1;
        @(negedge CLOCK_50);
        check("s7_rise_empty", fifo_count, 0);
        ev(0, 8'h21);
        ev(1, 8'h21);
        check("s7_count", fifo_count, 1);
        check("s7_hole",  hit_hole,   8);

        // Mid-operation reset, events during reset are lost
        @(negedge CLOCK_50); resetn = 1'b0;
        #1;
        check("s8_async_valid", hit_valid, 0);
        check("s8_async_held",  held,      0);
        @(negedge CLOCK_50);
        key_valid = 1'b1; key_make = 1'b1; key_code = 8'h15;
        @(negedge CLOCK_50);
        key_valid = 1'b0;
        resetn = 1'b1;
        @(negedge CLOCK_50);
        check("s8_lost_held",  held,       0);
        check("s8_lost_count", fifo_count, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            @(negedge CLOCK_50);
            key_valid    = ($urandom_range(0, 2) == 0);
            key_make     = $urandom_range(0, 1) != 0;
            key_code     = ($urandom_range(0, 7) != 0) ? codes[$urandom_range(0, 8)] : 8'($urandom);
            hit_ready    = ($urandom_range(0, 3) == 0);
            game_active  = ($urandom_range(0, 49) != 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
        end
        @(negedge CLOCK_50);
        key_valid = 1'b0; hit_ready = 1'b0; clr_overflow = 1'b0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
